// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle sequencer for the CPU control path.
//
// Emits the cycle code consumed by the instruction decoder:
//   FETCH 2'b00, EXEC1 2'b01, EXEC2 2'b10, HALT 2'b11.
// FETCH stretches while instruction memory is not ready. EXEC2 is taken only
// when the decoder asks for it. A halt request wins over everything outside
// HALT. The block also tracks the post-jump flag and counts retired
// instructions.
//
// Optional feature (macro CPU_SEQ_STEP_EN): adds the step_mode input. While
// step_mode is high, every retirement lands in HALT rather than FETCH, so each
// run pulse executes exactly one instruction.
//
// Parameters
//   CNT_WIDTH   width of the retired-instruction counter (wraps)
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   mem_ready   instruction RAM data valid; FETCH completes only when high
//   sm_extra    decoder request for EXEC2, sampled in EXEC1
//   stop        halt request, honoured in any non-HALT state
//   set_jump    current instruction redirected the PC
//   run         restart request, sampled only in HALT
//   step_mode   single-step enable (CPU_SEQ_STEP_EN builds only)
//   state       current cycle code (registered)
//   jump        high for the whole instruction following a PC redirect
//   instr_load  instruction-register load strobe (combinational)
//   halted      high in HALT (registered)
//   retired     completed-instruction count (registered)

module cpu_sequencer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_ready,
  input  logic                 sm_extra,
  input  logic                 stop,
  input  logic                 set_jump,
  input  logic                 run,
`ifdef CPU_SEQ_STEP_EN
  input  logic                 step_mode,
`endif
  output logic [1:0]           state,
  output logic                 jump,
  output logic                 instr_load,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec1 = 2'b01,
    StExec2 = 2'b10,
    StHalt  = 2'b11
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 jump_q, jump_d;
  logic                 redirect_q, redirect_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic step_active;
  logic retire;
  logic go_halt;

`ifdef CPU_SEQ_STEP_EN
  assign step_active = step_mode;
`else
  assign step_active = 1'b0;
`endif

  // Next-state, jump tracking and retirement.
  // redirect_q remembers a set_jump seen in EXEC1 of a 3-cycle instruction, so
  // that instruction's own EXEC2 retirement does not clear the flag meant for
  // the instruction that follows it.
  always_comb begin
    state_d    = state_q;
    jump_d     = jump_q;
    redirect_d = redirect_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    go_halt    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (stop) begin
          go_halt = 1'b1;
        end else if (mem_ready) begin
          state_d = StExec1;
        end
      end
      StExec1: begin
        if (stop) begin
          go_halt = 1'b1;
        end else if (sm_extra) begin
          state_d = StExec2;
          if (set_jump) begin
            jump_d     = 1'b1;
            redirect_d = 1'b1;
          end
        end else begin
          retire = 1'b1;
        end
      end
      StExec2: begin
        if (stop) begin
          go_halt = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      StHalt: begin
        // stop is deliberately ignored here; only run leaves HALT.
        if (run) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // A halting instruction is not counted and drops any pending jump.
    if (go_halt) begin
      state_d    = StHalt;
      jump_d     = 1'b0;
      redirect_d = 1'b0;
    end

    // Retirement: a redirect by this instruction (now or in EXEC1) marks the
    // next one; otherwise the flag that covered this instruction expires.
    if (retire) begin
      retired_d  = retired_q + CntOne;
      jump_d     = set_jump | redirect_q;
      redirect_d = 1'b0;
      state_d    = step_active ? StHalt : StFetch;
    end

    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      jump_q     <= 1'b0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      jump_q     <= jump_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  // Gated by reset so no load strobe escapes while the sequencer is held.
  assign instr_load = ~reset & (state_q == StFetch) & mem_ready & ~stop;

  assign state   = state_q;
  assign jump    = jump_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed scenarios followed by randomized
// stimulus, all compared against an instruction-level reference model.

module tb_cpu_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  // Model cycle codes, as the decoder sees them.
  localparam int F  = 0;
  localparam int E1 = 1;
  localparam int E2 = 2;
  localparam int H  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_ready, sm_extra, stop, set_jump, run;
  logic         step_mode;
  logic [1:0]   state;
  logic         jump, instr_load, halted;
  logic [W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int loads  = 0;

  // Reference model: cycle phase, retire count, and jump bookkeeping.
  int m_st;
  int m_retired;
  bit m_jump;    // current instruction follows a redirect
  bit m_redir;   // this instruction already redirected in an earlier cycle

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CNT_WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .sm_extra   (sm_extra),
    .stop       (stop),
    .set_jump   (set_jump),
    .run        (run),
`ifdef CPU_SEQ_STEP_EN
    .step_mode  (step_mode),
`endif
    .state      (state),
    .jump       (jump),
    .instr_load (instr_load),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit step_on();
`ifdef CPU_SEQ_STEP_EN
    return step_mode;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    m_st      = F;
    m_retired = 0;
    m_jump    = 0;
    m_redir   = 0;
  endfunction

  function automatic void model_halt();
    m_st    = H;
    m_jump  = 0;
    m_redir = 0;
  endfunction

  function automatic void model_retire();
    m_retired = (m_retired + 1) % MOD;
    m_jump    = set_jump || m_redir;
    m_redir   = 0;
    m_st      = step_on() ? H : F;
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  function automatic void model_clock();
    case (m_st)
      F:  if (stop) model_halt(); else if (mem_ready) m_st = E1;
      E1: begin
        if (stop) model_halt();
        else if (sm_extra) begin
          m_st = E2;
          if (set_jump) begin
            m_jump  = 1;
            m_redir = 1;
          end
        end else model_retire();
      end
      E2: if (stop) model_halt(); else model_retire();
      default: if (run) m_st = F;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".state"}, 32'(state), 32'(m_st));
    check_eq({tag, ".jump"}, 32'(jump), 32'(m_jump));
    check_eq({tag, ".retired"}, 32'(retired), 32'(m_retired));
    check_eq({tag, ".halted"}, 32'(halted), 32'(m_st == H));
    check_eq({tag, ".instr_load"}, 32'(instr_load),
             32'(m_st == F && mem_ready && !stop && !reset));
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle, advance.
  task automatic cycle(input bit mr, input bit se, input bit st, input bit sj, input bit rn);
    mem_ready = mr;
    sm_extra  = se;
    stop      = st;
    set_jump  = sj;
    run       = rn;
    #3;
    check_all("cyc");
    if (instr_load) loads++;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Reset asserted away from the clock edge; must take effect immediately.
  task automatic async_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    int seq_two[7];
    int bench_loads;
    seq_two = '{0, 1, 0, 1, 0, 1, 0};

    reset     = 1'b1;
    mem_ready = 1'b1;
    sm_extra  = 1'b0;
    stop      = 1'b0;
    set_jump  = 1'b0;
    run       = 1'b0;
    step_mode = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    check_eq("reset.state", 32'(state), 32'd0);
    check_eq("reset.load_gated", 32'(instr_load), 32'd0);
    reset = 1'b0;

    // Three 2-cycle instructions.
    loads = 0;
    for (int i = 0; i < 7; i++) begin
      check_eq("two_cycle.seq", 32'(state), 32'(seq_two[i]));
      if (i < 6) cycle(1, 0, 0, 0, 0);
    end
    check_eq("two_cycle.retired", 32'(retired), 32'd3);
    check_eq("two_cycle.loads", 32'(loads), 32'd3);

    // 3-cycle instruction: count moves only on EXEC2 -> FETCH.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check_eq("three_cycle.exec2", 32'(state), 32'd2);
    check_eq("three_cycle.no_count_yet", 32'(retired), 32'd3);
    cycle(1, 0, 0, 0, 0);
    check_eq("three_cycle.fetch", 32'(state), 32'd0);
    check_eq("three_cycle.retired", 32'(retired), 32'd4);

    // mem_ready low for 4 cycles holds FETCH 5 cycles, one load only.
    loads = 0;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    check_eq("wait.still_fetch", 32'(state), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check_eq("wait.exec1", 32'(state), 32'd1);
    check_eq("wait.loads", 32'(loads), 32'd1);
    cycle(1, 0, 0, 0, 0);

    // Jump: A redirects, B runs with jump high, then it clears.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    check_eq("jump.b_fetch", 32'(jump), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check_eq("jump.b_exec1", 32'(jump), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check_eq("jump.cleared", 32'(jump), 32'd0);
    // A redirects in EXEC1 of a 3-cycle instruction; B also redirects.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("jump.after_a3", 32'(jump), 32'd1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    check_eq("jump.b_sets_again", 32'(jump), 32'd1);

    // Halt with retired = 5, jump pending.
    async_reset("reset2");
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, (i == 9), 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check_eq("halt.state", 32'(state), 32'd3);
    check_eq("halt.halted", 32'(halted), 32'd1);
    check_eq("halt.retired", 32'(retired), 32'd5);
    check_eq("halt.jump", 32'(jump), 32'd0);
    cycle(1, 0, 1, 0, 0);
    check_eq("halt.stop_ignored", 32'(state), 32'd3);
    cycle(1, 0, 0, 0, 1);
    check_eq("halt.run", 32'(state), 32'd0);

`ifdef CPU_SEQ_STEP_EN
    // Single step: each run pulse retires exactly one instruction.
    step_mode = 1'b1;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("step.halt1", 32'(state), 32'd3);
    check_eq("step.count1", 32'(retired), 32'd6);
    cycle(1, 0, 0, 0, 0);
    check_eq("step.wait", 32'(state), 32'd3);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("step.halt2", 32'(state), 32'd3);
    check_eq("step.count2", 32'(retired), 32'd7);
    cycle(1, 0, 0, 0, 1);
    step_mode = 1'b0;
`endif

    // Reset asserted in EXEC2.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check_eq("rst_exec2.pre", 32'(state), 32'd2);
    async_reset("rst_exec2");
    check_eq("rst_exec2.state", 32'(state), 32'd0);
    check_eq("rst_exec2.retired", 32'(retired), 32'd0);

    // Randomized phase; the narrow counter wraps many times.
    bench_loads = 0;
    for (int n = 0; n < 4000; n++) begin
`ifdef CPU_SEQ_STEP_EN
      if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
`endif
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand_rst");
      end else begin
        cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
